load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of WAIT cycles without mem_ack before a fault is raised.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: request strobe; sampled only in IDLE.
REQ-005 Port is_load, input, 1: the request is a load.
REQ-006 Port is_store, input, 1: the request is a store.
REQ-007 Port funct3, input, 3: access size and sign (RV32I encoding).
REQ-008 Port addr, input, 32: byte address, taken from the ALU result.
REQ-009 Port store_data, input, 32: rs2 value for stores.
REQ-010 Port busy, output, 1: high whenever the state is not IDLE.
REQ-011 Port done, output, 1: one-cycle completion pulse.
REQ-012 Port fault, output, 1: one-cycle pulse, coincident with done, flagging an errored request.
REQ-013 Port load_data, output, 32: formatted load result.
REQ-014 Port mem_req, output, 1: memory request.
REQ-015 Port mem_we, output, 1: write enable.
REQ-016 Port mem_addr, output, 32: word-aligned address (addr with bits [1:0] forced to 0).
REQ-017 Port mem_wdata, output, 32: lane-replicated write data.
REQ-018 Port mem_be, output, 4: byte enables.
REQ-019 Port mem_rdata, input, 32: read data, valid when mem_ack is high.
REQ-020 Port mem_ack, input, 1: memory completion, sampled while in WAIT.

Function
REQ-021 FSM states SHALL be: IDLE, WAIT, DONE, ERR.
REQ-022 In IDLE, start=1 with exactly one of is_load/is_store high SHALL accept the request: latch addr, funct3, direction and store_data.
- start with both or neither of is_load/is_store SHALL be ignored.
REQ-023 Legal funct3 values SHALL be:
- loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
- stores: 000 SB, 001 SH, 010 SW.
REQ-024 An accepted request with illegal funct3 or a misaligned address (half access with addr[0]=1; word access with addr[1:0]!=0) SHALL go to ERR, and mem_req SHALL never assert for it.
REQ-025 An accepted legal request SHALL go to WAIT; mem_req SHALL be high for every WAIT cycle.
- mem_we, mem_addr, mem_wdata and mem_be SHALL stay stable until the cycle mem_ack is sampled high.
REQ-026 mem_be SHALL be:
- byte access: 4'b0001<<addr[1:0];
- half access: 4'b0011<<addr[1:0];
- word access: 4'b1111.
- The same mask SHALL be driven for loads, with mem_we=0.
REQ-027 mem_wdata SHALL be: SB {4{store_data[7:0]}}, SH {2{store_data[15:0]}}, SW store_data.
REQ-028 When mem_ack is sampled high in WAIT, the FSM SHALL go to DONE.
- For loads, the addressed lane of mem_rdata SHALL be registered into load_data: sign-extended for LB/LH, zero-extended for LBU/LHU, unmodified for LW.
REQ-029 load_data SHALL hold its value until the next successful load completes; stores and faults SHALL leave it unchanged.
REQ-030 A WAIT-cycle counter SHALL clear on entry to WAIT.
- If TIMEOUT cycles elapse with no mem_ack, the FSM SHALL go to ERR.
- An ack arriving in the final allowed cycle SHALL win over the timeout.
REQ-031 DONE SHALL drive done=1 for one cycle; ERR SHALL drive done=1 and fault=1 for one cycle. Both states SHALL then return to IDLE.
REQ-032 Latency from the start edge:
- ack in the first WAIT cycle: done two cycles after the start edge;
- fault for illegal/misaligned requests: done one cycle after the start edge.
REQ-033 A new start SHALL be accepted in the IDLE cycle immediately following DONE or ERR; start while busy=1 SHALL be ignored.

Reset
REQ-034 rst=1 SHALL immediately force:
- state to IDLE;
- busy, done, fault, mem_req and mem_we to 0;
- mem_addr, mem_wdata, load_data and the timeout counter to 0;
- mem_be to 4'b0000.
REQ-035 Reset asserted during WAIT SHALL abandon the request with no done pulse; mem_req SHALL drop asynchronously.

Verification
REQ-036 SW, addr=0x100, store_data=0xDEADBEEF, ack in the first WAIT cycle -> mem_addr=0x100, mem_be=1111, mem_we=1, done 2 cycles after start, fault=0.
REQ-037 SB, addr=0x103, store_data=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
REQ-038 LB at addr=0x102 with mem_rdata=0x12F45678 -> load_data=0xFFFFFFF4; LBU at the same address -> 0x000000F4; LHU at 0x102 -> 0x000012F4.
REQ-039 LW at addr=0x101 -> fault=1 and done=1 one cycle after start, mem_req never high, load_data unchanged.
REQ-040 LW with mem_ack withheld, TIMEOUT=16 -> fault after 16 WAIT cycles; repeat with ack in cycle 16 -> normal done, fault=0.
REQ-041 rst pulsed in the third WAIT cycle of a load -> mem_req=0 immediately, no done pulse, next start accepted normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Purpose  : Word-oriented memory bus between the load/store unit and the
//             data memory.
//  Signals  : mem_req   - access request, held for the whole access
//             mem_we    - write enable (store)
//             mem_addr  - word-aligned byte address
//             mem_wdata - lane-replicated write data
//             mem_be    - byte enables
//             mem_rdata - read data, valid while mem_ack is high
//             mem_ack   - access completion
//  Modports : master - the load/store unit
//             slave  - the memory
//  Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : RV32I load/store unit. Accepts one request at a time, checks
//             funct3 and alignment, runs a single memory access with an
//             ack timeout and formats load results.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             start             - request strobe (sampled in IDLE only)
//             is_load/is_store  - request direction (exactly one must be set)
//             funct3            - access size / sign
//             addr              - byte address
//             store_data        - rs2 value for stores
//             busy              - unit is not idle
//             done              - one-cycle completion pulse
//             fault             - one-cycle error pulse, coincident with done
//             load_data         - formatted result of the last good load
//             mem               - memory bus (master side)
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  input  wire logic        is_load,
  input  wire logic        is_store,
  input  wire logic [2:0]  funct3,
  input  wire logic [31:0] addr,
  input  wire logic [31:0] store_data,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [31:0]      load_data,
  load_store_unit_if.master mem
);

  // Counter holds 0 .. TIMEOUT-1; one spare bit keeps TIMEOUT=1 legal.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      load_data_q, load_data_d;

  // --------------------------------------------------------------------------
  // Request decode (operates on the live request inputs while in IDLE)
  // --------------------------------------------------------------------------
  logic        accept;
  logic        legal_f3;
  logic        aligned;
  logic        legal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  // Exactly one direction must be set; both or neither is not a request.
  assign accept = start & (is_load ^ is_store);

  always_comb begin
    legal_f3 = 1'b0;
    if (is_load) begin
      legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010};
    end
  end

  always_comb begin
    aligned   = 1'b1;
    req_be    = 4'b1111;
    req_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~addr[0];
        req_be    = 4'b0011 << addr[1:0];
        req_wdata = {2{store_data[15:0]}};
      end
      default: begin
        aligned   = (addr[1:0] == 2'b00);
        req_be    = 4'b1111;
        req_wdata = store_data;
      end
    endcase
  end

  assign legal = legal_f3 & aligned;

  // --------------------------------------------------------------------------
  // Load formatting: bring the addressed lane down to bit 0, then extend
  // --------------------------------------------------------------------------
  logic [31:0] lane_data;
  logic [31:0] fmt_data;

  always_comb begin
    lane_data = mem.mem_rdata;
    case (lane_q)
      2'd0:    lane_data = mem.mem_rdata;
      2'd1:    lane_data = {8'h00,  mem.mem_rdata[31:8]};
      2'd2:    lane_data = {16'h0000, mem.mem_rdata[31:16]};
      default: lane_data = {24'h000000, mem.mem_rdata[31:24]};
    endcase
  end

  always_comb begin
    fmt_data = lane_data;
    case (funct3_q)
      3'b000:  fmt_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  fmt_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  fmt_data = {24'h000000, lane_data[7:0]};
      3'b101:  fmt_data = {16'h0000, lane_data[15:0]};
      default: fmt_data = mem.mem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'b0000;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
    done        = 1'b0;
    fault       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = {addr[31:2], 2'b00};
          wdata_d  = req_wdata;
          be_d     = req_be;
          we_d     = is_store;
          funct3_d = funct3;
          lane_d   = addr[1:0];
          cnt_d    = '0;
          // Bad requests go straight to ERR and never touch the bus.
          state_d  = legal ? WAIT : ERR;
        end
      end
      WAIT: begin
        // The ack is checked before the timeout so an ack in the last
        // allowed cycle still completes normally.
        if (mem.mem_ack) begin
          state_d = DONE;
          if (!we_q) begin
            load_data_d = fmt_data;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        done    = 1'b1;
        fault   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Request and write enable are decoded from the state register so an
  // asynchronous reset drops them immediately.
  assign busy          = (state_q != IDLE);
  assign load_data     = load_data_q;
  assign mem.mem_req   = (state_q == WAIT);
  assign mem.mem_we    = (state_q == WAIT) & we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

endmodule
`default_nettype wire
